pipelined_rca: RTL and testbench

- Parametrised, pipelined successor to the decomposed ripple-carry adder.
- Splits the NBIT operands into NSEG segments of SEG bits. One segment is added per pipeline stage, and the carry is registered between stages.
- Adds subtract mode, carry-in, carry-out and signed-overflow outputs.
- Uses a valid/ready stream handshake, so it can sit in a datapath at full throughput: one operation per cycle.

---
 rtl/pipelined_rca_pkg.sv | 5 +
 rtl/pipelined_rca_segment.sv | 22 ++
 rtl/pipelined_rca.sv | 98 +++++++++
 tb/tb_pipelined_rca.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipelined_rca_pkg.sv
// pipelined_rca_pkg: shared width defaults for the ripple-carry adder family.
package pipelined_rca_pkg;
  localparam int NBIT_DEFAULT = 32;
  localparam int SEG_DEFAULT  = 8;
endpackage

// File: rtl/pipelined_rca_segment.sv
// pipelined_rca_segment: W-bit combinational ripple chain of full adders.
module pipelined_rca_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         CI,
  output logic [W-1:0] S,
  output logic         CO
);
  logic [W:0] c;
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = CI;
    for (int i = 0; i < W; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end
  assign CO = c[W];
endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: NBIT adder/subtractor, one SEG-bit segment per stage, valid/ready stream.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int NBIT = NBIT_DEFAULT,
  parameter int SEG  = SEG_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [NBIT-1:0] A,
  input  logic [NBIT-1:0] B,
  input  logic            CIN,
  input  logic            SUB,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [NBIT-1:0] S,
  output logic            COUT,
  output logic            OVF
);
  localparam int NSEG = NBIT / SEG;
  logic            adv;
  logic [NBIT-1:0] bx;
  assign bx       = SUB ? ~B : B;
  assign adv      = OUT_READY || !OUT_VALID;
  assign IN_READY = adv;
  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int LO = SEG * k;
    // w carries finished sum segments below LO and untouched A segments above
    logic [NBIT-1:0] w_i, w_d, w_q;
    logic [NBIT-1:LO] b_i;
    logic [SEG-1:0]  s_seg;
    logic            c_i, v_i, as_i, bs_i, co, c_q, v_q;
    if (k == 0) begin : g_in
      assign w_i  = A;
      assign b_i  = bx;
      assign c_i  = SUB | CIN;
      assign v_i  = IN_VALID;
      assign as_i = A[NBIT-1];
      assign bs_i = bx[NBIT-1];
    end else begin : g_chain
      assign w_i  = g_st[k-1].w_q;
      assign b_i  = g_st[k-1].g_fwd.b_q;
      assign c_i  = g_st[k-1].c_q;
      assign v_i  = g_st[k-1].v_q;
      assign as_i = g_st[k-1].g_fwd.as_q;
      assign bs_i = g_st[k-1].g_fwd.bs_q;
    end
    pipelined_rca_segment #(.W(SEG)) u_seg (
      .A (w_i[LO +: SEG]),
      .B (b_i[LO +: SEG]),
      .CI(c_i),
      .S (s_seg),
      .CO(co)
    );
    always_comb begin
      w_d            = w_i;
      w_d[LO +: SEG] = s_seg;
    end
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        v_q <= 1'b0;
        w_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_i;
        w_q <= w_d;
        c_q <= co;
      end
    end
    if (k < NSEG - 1) begin : g_fwd
      logic [NBIT-1:LO+SEG] b_q;
      logic                 as_q, bs_q;
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          b_q  <= '0;
          as_q <= 1'b0;
          bs_q <= 1'b0;
        end else if (adv) begin
          b_q  <= b_i[NBIT-1:LO+SEG];
          as_q <= as_i;
          bs_q <= bs_i;
        end
      end
    end else begin : g_out
      logic ovf_q;
      always_ff @(posedge CLK) begin
        if (!RST_N) ovf_q <= 1'b0;
        else if (adv) ovf_q <= (as_i == bs_i) && (w_d[NBIT-1] != as_i);
      end
    end
  end
  assign OUT_VALID = g_st[NSEG-1].v_q;
  assign S         = g_st[NSEG-1].w_q;
  assign COUT      = g_st[NSEG-1].c_q;
  assign OVF       = g_st[NSEG-1].g_out.ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed vector table plus streaming, stall and reset sequences.
module tb_pipelined_rca;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, s;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[11];
  always #5 clk = ~clk;
  pipelined_rca #(.NBIT(32), .SEG(8)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .CIN(cin), .SUB(sub),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .S(s), .COUT(cout), .OVF(ovf)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_one(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("early_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("valid", {31'b0, out_valid}, 32'd1);
    chk("sum", s, v.s);
    chk("cout", {31'b0, cout}, {31'b0, v.c});
    chk("ovf", {31'b0, ovf}, {31'b0, v.o});
    @(negedge clk);
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask
  initial begin
    logic [31:0] st_a[6], st_b[6], st_s[6], bp_s[5], hold_s;
    int          sent, got, stalls, ghost;
    logic        held;
    tbl[0]  = '{32'd2,        32'd3,        1'b0, 1'b0, 32'd5,        1'b0, 1'b0};
    tbl[1]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0};
    tbl[2]  = '{32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3]  = '{32'd7,        32'd8,        1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[4]  = '{32'd339,      32'd118,      1'b0, 1'b1, 32'd221,      1'b1, 1'b0};
    tbl[5]  = '{32'd2,        32'd3,        1'b1, 1'b0, 32'd6,        1'b0, 1'b0};
    tbl[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1};
    tbl[7]  = '{32'h80000000, 32'd1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[8]  = '{32'h000000FF, 32'd1,        1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    tbl[9]  = '{32'd5,        32'd5,        1'b0, 1'b1, 32'd0,        1'b1, 1'b0};
    tbl[10] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
    st_a = '{32'd0, 32'd2, 32'd7, 32'd17, 32'd77, 32'd77};
    st_b = '{32'd0, 32'd3, 32'd8, 32'd58, 32'd118, 32'd339};
    st_s = '{32'd0, 32'd5, 32'd15, 32'd75, 32'd195, 32'd416};
    bp_s = '{32'd3, 32'd110, 32'd217, 32'd324, 32'd431};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", s, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 11; i++) run_one(tbl[i]);
    // back-to-back stream: result j-4 expected at the negedge after edge j
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j >= 1) chk("stream_valid", {31'b0, out_valid}, {31'b0, (j >= 4 && j <= 9)});
      if (j >= 4 && j <= 9) chk("stream_sum", s, st_s[j-4]);
      in_valid = (j < 6);
      if (j < 6) begin a = st_a[j]; b = st_b[j]; cin = 1'b0; sub = 1'b0; end
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    // back-pressure: OUT_READY low on cycles 4..6 while five ops stream in
    sent = 0; got = 0; stalls = 0; held = 1'b0; hold_s = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid = (sent < 5);
      a = 100 * sent + 3; b = 7 * sent; cin = 1'b0; sub = 1'b0;
      #1;
      if (held) chk("stall_hold", s, hold_s);
      if (out_valid && out_ready) begin
        chk("bp_sum", s, bp_s[got]);
        got++;
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        hold_s = s; held = 1'b1; stalls++;
      end else held = 1'b0;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 32'd5);
    chk("bp_stalls", stalls, 32'd3);
    ghost = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk("bp_no_dup", ghost, 32'd0);
    // reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_sum", s, 32'd0);
    chk("mid_rst_cout", {31'b0, cout}, 32'd0);
    chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    ghost = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk("mid_rst_discard", ghost, 32'd0);
    run_one('{32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
